sram_controller_core: RTL and testbench

SRAM_CONTROLLER_CORE -- requirements
Module: SRAM_Controller

---
 rtl/sram_controller_core.sv | 53 +++++
 tb/tb_sram_controller_core.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/sram_controller_core.sv
// Minimal SRAM write controller: registers a write request and its data,
// drives the SRAM strobes from that register, and releases the shared data
// bus whenever no write is in progress so external read data can be seen.
module sram_controller_core #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] in,
   output logic [DATA_WIDTH-1:0] out,
   output logic                  CSX,
   output logic                  OEX,
   output logic                  WEX,
   inout  wire  [DATA_WIDTH-1:0] DATA
);

   logic                  r_wr;
   logic [DATA_WIDTH-1:0] r_dreg;
   logic [DATA_WIDTH-1:0] w_busDrive;

   // Write-phase flag follows the request one cycle late; reset aborts at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr <= 1'b0;
      end else begin
         r_wr <= load;
      end
   end

   // Write data is captured only alongside a request and held otherwise
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dreg <= '0;
      end else if (load) begin
         r_dreg <= in;
      end
   end

   // Bus is driven only during a write phase, otherwise left floating
   always_comb begin
      w_busDrive = r_dreg;
   end

   assign DATA = r_wr ? w_busDrive : {DATA_WIDTH{1'bz}};
   assign out  = DATA;

   // Chip stays selected except while reset holds the device off the bus
   assign CSX = reset;
   assign OEX = r_wr;
   assign WEX = ~r_wr;

endmodule

// File: tb/tb_sram_controller_core.sv
// Randomised self-checking bench for sram_controller_core.
module tb_sram_controller_core;

   localparam int W = 16;

   logic         clk;
   logic         reset;
   logic         load;
   logic [W-1:0] in;
   logic [W-1:0] out;
   logic         CSX;
   logic         OEX;
   logic         WEX;
   wire  [W-1:0] DATA;

   logic         extEn;
   logic [W-1:0] extData;

   int vectors;
   int miscompares;

   // Queue of write data the model expects to see on the bus, one entry per request
   logic [W-1:0] pendingWrites[$];

   assign DATA = extEn ? extData : {W{1'bz}};

   sram_controller_core #(.DATA_WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .in    (in),
      .out   (out),
      .CSX   (CSX),
      .OEX   (OEX),
      .WEX   (WEX),
      .DATA  (DATA)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: present a request, let the edge take it, then check the
   // write phase (or idle phase) that the model says must follow that edge.
   task automatic applyStimulus(input logic ld, input logic [W-1:0] d);
      logic         expWr;
      logic [W-1:0] expData;
      @(negedge clk);
      load = ld;
      in   = d;
      if (ld) pendingWrites.push_back(d);
      @(posedge clk);
      expWr   = 1'b0;
      expData = '0;
      if (ld) begin
         expData = pendingWrites.pop_front();
         expWr   = !reset;
      end
      #1;
      extEn   = !expWr;
      extData = W'($urandom);
      #1;
      checkOutput("CSX", {15'd0, CSX}, {15'd0, reset});
      checkOutput("OEX", {15'd0, OEX}, {15'd0, expWr});
      checkOutput("WEX", {15'd0, WEX}, {15'd0, !expWr});
      checkOutput("out", out, expWr ? expData : extData);
   endtask

   // Main sequence: reset, idle, single, periodic, back-to-back, reset abort, random
   initial begin
      vectors     = 0;
      miscompares = 0;
      reset   = 1'b1;
      load    = 1'b0;
      in      = '0;
      extEn   = 1'b1;
      extData = 16'h5A5A;
      #2;
      checkOutput("rstCSX", {15'd0, CSX}, 16'd1);
      checkOutput("rstOEX", {15'd0, OEX}, 16'd0);
      checkOutput("rstWEX", {15'd0, WEX}, 16'd1);
      checkOutput("rstOut", out, 16'h5A5A);

      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0);

      applyStimulus(1'b1, 16'hA5C3);
      checkOutput("pinSingle", out, 16'hA5C3);
      applyStimulus(1'b0, '0);
      checkOutput("pinSingleEndWEX", {15'd0, WEX}, 16'd1);

      for (int i = 0; i < 24; i++) begin
         applyStimulus((i % 4 == 0) && (i < 20), W'($urandom));
      end

      applyStimulus(1'b1, 16'h0001);
      applyStimulus(1'b1, 16'h0002);
      applyStimulus(1'b1, 16'h0003);
      checkOutput("pinB2B", out, 16'h0003);
      checkOutput("pinB2BWEX", {15'd0, WEX}, 16'd0);
      applyStimulus(1'b0, '0);

      applyStimulus(1'b1, 16'hFFFF);
      checkOutput("pinMidWrite", out, 16'hFFFF);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("abortCSX", {15'd0, CSX}, 16'd1);
      checkOutput("abortOEX", {15'd0, OEX}, 16'd0);
      checkOutput("abortWEX", {15'd0, WEX}, 16'd1);
      extEn   = 1'b1;
      extData = 16'h1234;
      #1;
      checkOutput("abortRelease", out, 16'h1234);
      applyStimulus(1'b0, '0);
      applyStimulus(1'b1, 16'hBEEF);
      @(negedge clk);
      reset = 1'b0;
      load  = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0);

      for (int i = 0; i < 60; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), W'($urandom));
      end
      applyStimulus(1'b0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
